// File: rtl/avgpool_if.sv
// Bus bundle for the 2x2 average-pooling sequencer.
// It carries the controller handshake, the input RAM read port and the pooled-result write port.
interface avgpool_if #(
    parameter int DW  = 16,
    parameter int AW  = 10,
    parameter int OAW = 8
) ();
    logic           start;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic           out_valid;
    logic           out_ready;
    logic [OAW-1:0] out_addr;
    logic [DW-1:0]  out_data;

    // Environment side: layer controller, input RAM and downstream buffer.
    modport master (
        output start, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, out_valid, out_addr, out_data
    );

    // Sequencer side.
    modport slave (
        input  start, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/avgpool_seq.sv
// 2x2 average-pooling sequencer.
// It walks the non-overlapping windows of a feature map in raster order and issues four RAM reads per window.
// It accumulates the taps and emits floor(sum/4) per window over a valid/ready port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// FETCH   | t=0..3 issue tap reads, t=1..4 accumulate returning data
// EMIT    | pooled value presented, waiting for out_ready
// DONE    | one-cycle done pulse, then back to IDLE
module avgpool_seq #(
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28,
    parameter int DW     = 16,
    parameter int AW     = 10,
    parameter int OAW    = 8
) (
    input  logic     clk,
    input  logic     rst,
    avgpool_if.slave bus
);

    localparam int WC_MAX = WIDTH / 2 - 1;
    localparam int WR_MAX = HEIGHT / 2 - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           t_q, t_d;
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        wc_q, wc_d;
    logic signed [DW+1:0] acc_q, acc_d;

    logic [AW-1:0]        tap_row;
    logic [AW-1:0]        tap_col;
    logic [AW-1:0]        tap_addr;
    logic                 fetch_rd;
    logic                 emit;
    logic                 last_win;

    // State and datapath registers; reset abandons any pass in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            acc_q   <= acc_d;
        end
    end

    assign last_win = (wr_q == AW'(WR_MAX)) && (wc_q == AW'(WC_MAX));

    // Next-state, window walk and accumulation.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        wr_d    = wr_q;
        wc_d    = wc_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    t_d     = '0;
                    wr_d    = '0;
                    wc_d    = '0;
                    acc_d   = '0;
                end
            end
            ST_FETCH: begin
                // Read data lags the strobe by one cycle, so tap t-1 lands while t is on the address bus.
                if (t_q != 3'd0) begin
                    acc_d = acc_q + (DW+2)'($signed(bus.rd_data));
                end
                if (t_q == 3'd4) begin
                    state_d = ST_EMIT;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    if (last_win) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        t_d     = '0;
                        acc_d   = '0;
                        if (wc_q == AW'(WC_MAX)) begin
                            wc_d = '0;
                            wr_d = wr_q + AW'(1);
                        end else begin
                            wc_d = wc_q + AW'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tap address: bit 1 of t selects the lower row, bit 0 selects the right column.
    always_comb begin
        tap_row  = AW'({wr_q, t_q[1]});
        tap_col  = AW'({wc_q, t_q[0]});
        tap_addr = AW'(32'(tap_row) * WIDTH + 32'(tap_col));
    end

    assign fetch_rd = (state_q == ST_FETCH) && (t_q != 3'd4);
    assign emit     = (state_q == ST_EMIT);

    // Outputs are gated to zero outside their active state so that reset clears them immediately.
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.rd_en     = fetch_rd;
    assign bus.rd_addr   = fetch_rd ? tap_addr : '0;
    assign bus.out_valid = emit;
    assign bus.out_addr  = emit ? OAW'(32'(wr_q) * (WIDTH / 2) + 32'(wc_q)) : '0;
    assign bus.out_data  = emit ? acc_q[DW+1:2] : '0;

endmodule
